bram_dual_port_be: RTL and testbench
====================================

Name: bram_dual_port_be

Overview:
True dual-port block RAM with per-byte write enables, a selectable read-during-write mode and an optional output register stage. It adds a read-valid strobe per port and a same-address collision flag. It serves as the general storage primitive for the next generation of buffers (packet stores, coefficient tables, ping-pong frames). Both ports run on the single clock.

Parameters:
DATA_WIDTH, 16, word width in bits; must be an integer multiple of BYTE_WIDTH.
ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH words.
BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
WRITE_MODE, 0, read-during-write on the same port: 0 write-first, 1 read-first, 2 no-change.
OUT_REG, 1, 0 = one-cycle read latency; 1 = extra output register (two-cycle latency).

Ports:
clk  in  1  single clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
en_a  in  1  port A access enable.
we_a  in  NB  port A byte write enables; all zero means a read.
addr_a  in  ADDR_WIDTH  port A address.
di_a  in  DATA_WIDTH  port A write data.
dout_a  out  DATA_WIDTH  port A read data.
dvalid_a  out  1  dout_a holds the result of an access.
en_b, we_b, addr_b, di_b, dout_b, dvalid_b  as for port A, for port B.
collision  out  1  one-cycle pulse: both ports enabled, same address, at least one writing.

Behaviour:
- Reset: synchronous, active-high, as already decided. While rst=1 on an edge: dout_a/b=0, dvalid_a/b=0, collision=0, all pipeline stages cleared. Memory contents are retained. en_a/en_b are ignored, so no writes and no reads are launched. Accesses in flight when rst rises are discarded, with no dvalid.
- Access stage (edge N, en_x=1): for each lane i with we_x[i]=1, mem[addr][i*BW +: BW] <= di_x lane i. Lanes with we_x[i]=0 are unchanged.
- Port result by mode:
  - Read (we_x all zero): result = mem[addr] before edge N.
  - Write, write-first: result = merged word (new lanes where we=1, old lanes elsewhere).
  - Write, read-first: result = old word.
  - Write, no-change: no result. dout_x holds its value and dvalid_x=0 for this access.
- Latency and dvalid:
  - OUT_REG=0: result on dout_x after edge N; dvalid_x=1 for exactly that cycle.
  - OUT_REG=1: result after edge N+1; dvalid_x aligned with it.
  - dout_x holds its last value when there is no new result. dvalid_x=0 unless a result is presented.
  - Back-to-back accesses give one result per cycle with no bubbles.
- Mixed-port rules (same address, same edge):
  - A reads, B writes (or vice versa): the reader gets the old word.
  - Both write: per lane, port A wins where both we bits are set; lanes written by only one port take that port's data. Each port's write-first result reports the word it wrote merged with the old word, not the final memory content.
  - collision pulses at the same cycle the access results appear on the outputs, i.e. it obeys the OUT_REG latency. It never asserts for two reads.
- Address wrap: none; every address is in range by construction.
- Uninitialised memory reads X in simulation; the bench must write before checking.
- Parameter check: elaboration error if DATA_WIDTH % BYTE_WIDTH != 0, WRITE_MODE > 2, or OUT_REG > 1.

Decomposition:
- Shared package bram_pkg: write-mode constants WM_WRITE_FIRST=0, WM_READ_FIRST=1, WM_NO_CHANGE=2, plus a helper function returning NB.
- Sub-module bram_out_pipe, instantiated once per port: holds result and valid, with optional second register stage (OUT_REG) and synchronous clear on rst.
- The top level holds the memory array, byte merge, mode selection and collision detect.

Test Plan:
1. OUT_REG=1, WRITE_MODE=0: write A addr 0x10 di 0xBEEF we=11, then read A 0x10 -> dout_a=0xBEEF with dvalid_a high exactly 2 cycles after each edge; the write itself also returns 0xBEEF.
2. Byte enables: mem[0x20]=0x1234; write B di 0xABCD we=01 -> subsequent read = 0x12CD. Under WRITE_MODE=1 the write returns 0x1234; under WRITE_MODE=2 the write gives dvalid_b=0 and dout_b unchanged.
3. Mixed port: mem[0x30]=0x0000; same edge A reads 0x30, B writes 0x5555 -> dout_a=0x0000, collision=1 (one cycle); next read = 0x5555.
4. Dual write: A writes 0xAAAA we=11, B writes 0xBBBB we=10 at 0x40 -> mem[0x40]=0xAAAA, collision=1. A writes 0x00AA we=01, B writes 0xBB00 we=10 -> mem=0xBBAA.
5. Streaming: OUT_REG=0, reads on A of addr 0..255 on consecutive cycles -> 256 consecutive dvalid_a pulses with data in order, no gaps.
6. Reset mid-operation: issue a read, assert rst the next cycle -> no dvalid for that read, dout=0. A write with en_a=1 during rst leaves memory unchanged, and earlier contents read back intact after reset.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared constants and helpers for the dual-port byte-enable block RAM family.
package bram_pkg;

    localparam int unsigned WM_WRITE_FIRST = 0;
    localparam int unsigned WM_READ_FIRST  = 1;
    localparam int unsigned WM_NO_CHANGE   = 2;

    function automatic int unsigned num_bytes(input int unsigned data_width,
                                              input int unsigned byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/bram_out_pipe.sv
// Per-port result/valid holder with an optional second register stage.
module bram_out_pipe
    import bram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned OUT_REG    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dvalid
);

    logic [DATA_WIDTH-1:0] s1_data_q, s2_data_q;
    logic                  s1_valid_q, s2_valid_q;

    // Data registers only load on a valid result so dout holds between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
            s2_valid_q <= s1_valid_q;
            if (in_valid) begin
                s1_data_q <= in_data;
            end
            if (s1_valid_q) begin
                s2_data_q <= s1_data_q;
            end
        end
    end

    assign dout   = (OUT_REG == 1) ? s2_data_q  : s1_data_q;
    assign dvalid = (OUT_REG == 1) ? s2_valid_q : s1_valid_q;

endmodule

// File: rtl/bram_dual_port_be.sv
// True dual-port block RAM with byte enables, selectable read-during-write
// behaviour, optional output register, per-port read-valid and collision flag.
module bram_dual_port_be
    import bram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned WRITE_MODE = 0,
    parameter int unsigned OUT_REG    = 1,
    localparam int unsigned NB        = num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_a,
    input  logic [NB-1:0]         we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] di_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    output logic                  dvalid_a,
    input  logic                  en_b,
    input  logic [NB-1:0]         we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] di_b,
    output logic [DATA_WIDTH-1:0] dout_b,
    output logic                  dvalid_b,
    output logic                  collision
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (WRITE_MODE > 2) begin : g_bad_mode
        $error("WRITE_MODE must be 0, 1 or 2");
    end
    if (OUT_REG > 1) begin : g_bad_outreg
        $error("OUT_REG must be 0 or 1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] old_a, old_b;
    logic [DATA_WIDTH-1:0] merged_a, merged_b;
    logic [DATA_WIDTH-1:0] res_data_a, res_data_b;
    logic                  res_valid_a, res_valid_b;
    logic                  coll_now;
    logic                  coll_q1, coll_q2;

    // Each port's write-first result is its own write merged with the old word,
    // independent of what the other port writes on the same edge.
    always_comb begin
        old_a    = mem[addr_a];
        old_b    = mem[addr_b];
        merged_a = old_a;
        merged_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (we_a[i]) begin
                merged_a[i*BYTE_WIDTH +: BYTE_WIDTH] = di_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (we_b[i]) begin
                merged_b[i*BYTE_WIDTH +: BYTE_WIDTH] = di_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_comb begin
        res_valid_a = 1'b0;
        res_data_a  = old_a;
        if (en_a && !rst) begin
            if (|we_a) begin
                if (WRITE_MODE == WM_WRITE_FIRST) begin
                    res_valid_a = 1'b1;
                    res_data_a  = merged_a;
                end else if (WRITE_MODE == WM_READ_FIRST) begin
                    res_valid_a = 1'b1;
                end
            end else begin
                res_valid_a = 1'b1;
            end
        end
    end

    always_comb begin
        res_valid_b = 1'b0;
        res_data_b  = old_b;
        if (en_b && !rst) begin
            if (|we_b) begin
                if (WRITE_MODE == WM_WRITE_FIRST) begin
                    res_valid_b = 1'b1;
                    res_data_b  = merged_b;
                end else if (WRITE_MODE == WM_READ_FIRST) begin
                    res_valid_b = 1'b1;
                end
            end else begin
                res_valid_b = 1'b1;
            end
        end
    end

    // Port B lanes are assigned first so port A wins lanes both ports write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NB; i++) begin
                if (en_b && we_b[i]) begin
                    mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= di_b[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
                if (en_a && we_a[i]) begin
                    mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= di_a[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign coll_now = en_a && en_b && (addr_a == addr_b) && ((|we_a) || (|we_b));

    always_ff @(posedge clk) begin
        if (rst) begin
            coll_q1 <= 1'b0;
            coll_q2 <= 1'b0;
        end else begin
            coll_q1 <= coll_now;
            coll_q2 <= coll_q1;
        end
    end

    assign collision = (OUT_REG == 1) ? coll_q2 : coll_q1;

    bram_out_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_pipe_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (res_valid_a),
        .in_data  (res_data_a),
        .dout     (dout_a),
        .dvalid   (dvalid_a)
    );

    bram_out_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_pipe_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (res_valid_b),
        .in_data  (res_data_b),
        .dout     (dout_b),
        .dvalid   (dvalid_b)
    );

endmodule

// File: tb/tb_bram_dual_port_be.sv
// Three RAM configurations share one stimulus stream and are checked against
// a behavioural word/lane model every cycle.
module tb_bram_dual_port_be;

    localparam int WM_CFG [3] = '{0, 1, 2};
    localparam int OR_CFG [3] = '{1, 0, 1};

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b;
    logic [1:0]  we_a, we_b;
    logic [7:0]  addr_a, addr_b;
    logic [15:0] di_a, di_b;

    logic [15:0] dout_a_s [3];
    logic [15:0] dout_b_s [3];
    logic [2:0]  dvalid_a_s, dvalid_b_s, collision_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bram_dual_port_be #(.WRITE_MODE(0), .OUT_REG(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .di_a(di_a),
        .dout_a(dout_a_s[0]), .dvalid_a(dvalid_a_s[0]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .di_b(di_b),
        .dout_b(dout_b_s[0]), .dvalid_b(dvalid_b_s[0]),
        .collision(collision_s[0])
    );

    bram_dual_port_be #(.WRITE_MODE(1), .OUT_REG(0)) u_dut1 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .di_a(di_a),
        .dout_a(dout_a_s[1]), .dvalid_a(dvalid_a_s[1]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .di_b(di_b),
        .dout_b(dout_b_s[1]), .dvalid_b(dvalid_b_s[1]),
        .collision(collision_s[1])
    );

    bram_dual_port_be #(.WRITE_MODE(2), .OUT_REG(1)) u_dut2 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .di_a(di_a),
        .dout_a(dout_a_s[2]), .dvalid_a(dvalid_a_s[2]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .di_b(di_b),
        .dout_b(dout_b_s[2]), .dvalid_b(dvalid_b_s[2]),
        .collision(collision_s[2])
    );

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endfunction

    // Behavioural model: memory contents, per-access results delayed by latency.
    logic [15:0] mem_m [256];
    logic [15:0] res_d [3][2][2];
    bit          res_v [3][2][2];
    bit          coll_h [2];
    logic [15:0] exp_dout [3][2];
    bit          exp_dv [3][2];
    bit          exp_coll [3];

    always @(posedge clk) begin
        bit          p_en [2];
        logic [1:0]  p_we [2];
        logic [7:0]  p_ad [2];
        logic [15:0] p_di [2];
        logic [15:0] old_w, new_w;
        bit          coll;
        p_en[0] = en_a; p_we[0] = we_a; p_ad[0] = addr_a; p_di[0] = di_a;
        p_en[1] = en_b; p_we[1] = we_b; p_ad[1] = addr_b; p_di[1] = di_b;
        coll = en_a && en_b && addr_a == addr_b && (we_a != 0 || we_b != 0);
        if (rst) begin
            coll_h[0] = 0;
            coll_h[1] = 0;
        end else begin
            coll_h[1] = coll_h[0];
            coll_h[0] = coll;
        end
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (rst) begin
                    res_v[k][p][0] = 0;
                    res_v[k][p][1] = 0;
                    exp_dout[k][p] = 16'h0;
                end else begin
                    res_v[k][p][1] = res_v[k][p][0];
                    res_d[k][p][1] = res_d[k][p][0];
                    old_w = mem_m[p_ad[p]];
                    new_w = old_w;
                    for (int l = 0; l < 2; l++)
                        if (p_we[p][l]) new_w[l*8 +: 8] = p_di[p][l*8 +: 8];
                    res_v[k][p][0] = p_en[p] && !(p_we[p] != 0 && WM_CFG[k] == 2);
                    res_d[k][p][0] = (p_we[p] != 0 && WM_CFG[k] == 0) ? new_w : old_w;
                end
                exp_dv[k][p] = res_v[k][p][OR_CFG[k]];
                if (exp_dv[k][p]) exp_dout[k][p] = res_d[k][p][OR_CFG[k]];
            end
            exp_coll[k] = coll_h[OR_CFG[k]];
        end
        if (!rst) begin
            for (int l = 0; l < 2; l++) begin
                if (en_b && we_b[l]) mem_m[addr_b][l*8 +: 8] = di_b[l*8 +: 8];
                if (en_a && we_a[l]) mem_m[addr_a][l*8 +: 8] = di_a[l*8 +: 8];
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("dut%0d dvalid_a", k), dvalid_a_s[k], exp_dv[k][0]);
            check($sformatf("dut%0d dvalid_b", k), dvalid_b_s[k], exp_dv[k][1]);
            check($sformatf("dut%0d collision", k), collision_s[k], exp_coll[k]);
            if (!$isunknown(exp_dout[k][0]))
                check($sformatf("dut%0d dout_a", k), dout_a_s[k], exp_dout[k][0]);
            if (!$isunknown(exp_dout[k][1]))
                check($sformatf("dut%0d dout_b", k), dout_b_s[k], exp_dout[k][1]);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive(input bit ea, input logic [1:0] wa, input logic [7:0] aa,
                         input logic [15:0] da, input bit eb, input logic [1:0] wb,
                         input logic [7:0] ab, input logic [15:0] db);
        en_a = ea; we_a = wa; addr_a = aa; di_a = da;
        en_b = eb; we_b = wb; addr_b = ab; di_b = db;
    endtask

    task automatic idle();
        drive(0, 2'b00, 8'h0, 16'h0, 0, 2'b00, 8'h0, 16'h0);
    endtask

    initial begin
        int pulses;
        rst = 1'b1;
        idle();
        repeat (3) cyc();
        for (int k = 0; k < 3; k++) begin
            check("reset dout_a", dout_a_s[k], 16'h0);
            check("reset dvalid_a", dvalid_a_s[k], 0);
            check("reset collision", collision_s[k], 0);
        end
        rst = 1'b0;

        for (int a = 0; a < 256; a++) begin
            drive(1, 2'b11, a[7:0], 16'($urandom), 0, 2'b00, 8'h0, 16'h0);
            cyc();
        end
        idle(); cyc(); cyc();

        // Write then read 0x10 on the two-cycle write-first configuration.
        drive(1, 2'b11, 8'h10, 16'hBEEF, 0, 2'b00, 8'h0, 16'h0); cyc();
        drive(1, 2'b00, 8'h10, 16'h0, 0, 2'b00, 8'h0, 16'h0); cyc();
        check("t1 write result", dout_a_s[0], 16'hBEEF);
        check("t1 write dvalid", dvalid_a_s[0], 1);
        idle(); cyc();
        check("t1 read result", dout_a_s[0], 16'hBEEF);
        check("t1 read dvalid", dvalid_a_s[0], 1);
        cyc();
        check("t1 dvalid drops", dvalid_a_s[0], 0);

        // Byte-enable write on port B.
        drive(1, 2'b11, 8'h20, 16'h1234, 0, 2'b00, 8'h0, 16'h0); cyc();
        drive(0, 2'b00, 8'h0, 16'h0, 1, 2'b01, 8'h20, 16'hABCD); cyc();
        check("t2 read-first result", dout_b_s[1], 16'h1234);
        idle(); cyc();
        check("t2 write-first result", dout_b_s[0], 16'h12CD);
        check("t2 no-change dvalid", dvalid_b_s[2], 0);
        drive(0, 2'b00, 8'h0, 16'h0, 1, 2'b00, 8'h20, 16'h0); cyc();
        check("t2 readback", dout_b_s[1], 16'h12CD);
        check("t2 model word", mem_m[8'h20], 16'h12CD);

        // A reads while B writes the same word.
        drive(1, 2'b11, 8'h30, 16'h0000, 0, 2'b00, 8'h0, 16'h0); cyc();
        drive(1, 2'b00, 8'h30, 16'h0, 1, 2'b11, 8'h30, 16'h5555); cyc();
        check("t3 collision or0", collision_s[1], 1);
        check("t3 reader old word", dout_a_s[1], 16'h0000);
        idle(); cyc();
        check("t3 collision pulse ends", collision_s[1], 0);
        check("t3 collision or1", collision_s[0], 1);
        drive(1, 2'b00, 8'h30, 16'h0, 0, 2'b00, 8'h0, 16'h0); cyc();
        check("t3 readback", dout_a_s[1], 16'h5555);

        // Both ports write the same word.
        drive(1, 2'b11, 8'h40, 16'hAAAA, 1, 2'b10, 8'h40, 16'hBBBB); cyc();
        check("t4 collision", collision_s[1], 1);
        drive(1, 2'b00, 8'h40, 16'h0, 0, 2'b00, 8'h0, 16'h0); cyc();
        check("t4 port A wins", dout_a_s[1], 16'hAAAA);
        drive(1, 2'b01, 8'h40, 16'h00AA, 1, 2'b10, 8'h40, 16'hBB00); cyc();
        drive(1, 2'b00, 8'h40, 16'h0, 0, 2'b00, 8'h0, 16'h0); cyc();
        check("t4 disjoint lanes", dout_a_s[1], 16'hBBAA);
        check("t4 model word", mem_m[8'h40], 16'hBBAA);

        // Streaming reads with one-cycle latency.
        pulses = 0;
        for (int a = 0; a < 256; a++) begin
            drive(1, 2'b00, a[7:0], 16'h0, 0, 2'b00, 8'h0, 16'h0);
            cyc();
            if (dvalid_a_s[1] === 1'b1 && dout_a_s[1] === mem_m[a]) pulses++;
        end
        check("t5 in-order pulses", pulses, 256);
        idle(); cyc();

        // Reset while a read is in flight; write under reset is ignored.
        drive(1, 2'b00, 8'h10, 16'h0, 0, 2'b00, 8'h0, 16'h0); cyc();
        rst = 1'b1;
        drive(1, 2'b11, 8'h10, 16'h0000, 0, 2'b00, 8'h0, 16'h0); cyc();
        check("t6 in-flight dropped", dvalid_a_s[0], 0);
        check("t6 dout cleared", dout_a_s[0], 16'h0);
        cyc();
        rst = 1'b0;
        idle(); cyc();
        check("t6 no late dvalid", dvalid_a_s[0], 0);
        drive(1, 2'b00, 8'h10, 16'h0, 0, 2'b00, 8'h0, 16'h0); cyc();
        idle(); cyc();
        check("t6 contents kept", dout_a_s[0], 16'hBEEF);

        // Random traffic over a narrow address window to provoke collisions.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 1) != 0) ? 2'($urandom) : 2'b00,
                  8'($urandom_range(0, 7)), 16'($urandom),
                  $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 1) != 0) ? 2'($urandom) : 2'b00,
                  8'($urandom_range(0, 7)), 16'($urandom));
            cyc();
        end
        rst = 1'b0;
        idle();
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
